// File: rtl/uni_axi_pkg.sv
// Shared types and constants for the uni-to-AXI bridge: FSM states, AXI burst/size
// encodings, request type encoding and a small size decoding helper.
package uni_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WADDR = 3'd3,
    ST_WRESP = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
  localparam logic [7:0] AXI_LEN_LINE   = 8'd1;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam int         AXI_ID_W       = 4;

  localparam logic REQ_WRITE = 1'b1;
  localparam logic REQ_READ  = 1'b0;

  // uni_size encodes log2 of the byte count
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/uni_axi_bridge_wstrb_gen.sv
// Write lane steering: turns a uni size/offset into an AXI byte strobe and moves
// the payload onto the addressed byte lanes. Cached line beats pass through unshifted.
module axi_wstrb_gen
  import uni_axi_pkg::*;
#(
  parameter int DW = 64,
  localparam int SW = DW / 8,
  localparam int OW = $clog2(SW)
) (
  input  logic          i_cachable,
  input  logic [OW-1:0] i_offset,
  input  logic [1:0]    i_size,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic [SW-1:0] o_strb
);

  logic [3:0]    w_nbytes;
  logic [SW-1:0] w_base;

  // Build the low-aligned byte mask, then shift mask and data to the lane offset
  always_comb begin
    w_nbytes = size_bytes(i_size);
    w_base   = '0;
    for (int b = 0; b < SW; b++) begin
      w_base[b] = (b < int'(w_nbytes));
    end
    if (i_cachable) begin
      o_strb = '1;
      o_data = i_data;
    end else begin
      o_strb = w_base << i_offset;
      o_data = i_data << {i_offset, 3'b000};
    end
  end

endmodule

// File: rtl/uni_axi_bridge.sv
// Bridges a single-outstanding uni request port onto AXI: cached requests become
// two-beat INCR line bursts, uncached ones single beats; one completion pulse per request.
module uni_axi_bridge
  import uni_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int AXI_DW = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_uni_valid,
  input  logic                  i_uni_reqtyp,
  input  logic [ADDR_W-1:0]     i_uni_addr,
  input  logic [2*AXI_DW-1:0]   i_uni_wdata,
  input  logic [1:0]            i_uni_size,
  input  logic                  i_uni_cachable,
  output logic                  o_uni_ready,
  output logic [2*AXI_DW-1:0]   o_uni_rdata,
  output logic                  o_axi_arvalid,
  output logic [AXI_ID_W-1:0]   o_axi_arid,
  output logic [ADDR_W-1:0]     o_axi_araddr,
  output logic [7:0]            o_axi_arlen,
  output logic [2:0]            o_axi_arsize,
  output logic [1:0]            o_axi_arburst,
  input  logic                  i_axi_arready,
  input  logic                  i_axi_rvalid,
  input  logic [AXI_DW-1:0]     i_axi_rdata,
  input  logic [1:0]            i_axi_rresp,
  input  logic                  i_axi_rlast,
  output logic                  o_axi_rready,
  output logic                  o_axi_awvalid,
  output logic [AXI_ID_W-1:0]   o_axi_awid,
  output logic [ADDR_W-1:0]     o_axi_awaddr,
  output logic [7:0]            o_axi_awlen,
  output logic [2:0]            o_axi_awsize,
  output logic [1:0]            o_axi_awburst,
  input  logic                  i_axi_awready,
  output logic                  o_axi_wvalid,
  output logic [AXI_DW-1:0]     o_axi_wdata,
  output logic [AXI_DW/8-1:0]   o_axi_wstrb,
  output logic                  o_axi_wlast,
  input  logic                  i_axi_wready,
  input  logic                  i_axi_bvalid,
  input  logic [1:0]            i_axi_bresp,
  output logic                  o_axi_bready
);

  localparam int STRB_W   = AXI_DW / 8;
  localparam int OFF_W    = $clog2(STRB_W);
  localparam int LINE_OFF = $clog2(2 * STRB_W);

  state_e                r_state;
  logic                  r_cach;
  logic [AXI_DW-1:0]     r_wdata_hi;
  logic                  r_rbeat;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic                  r_uni_ready;
  logic [2*AXI_DW-1:0]   r_rdata;
  logic                  r_arvalid;
  logic [ADDR_W-1:0]     r_araddr;
  logic [7:0]            r_arlen;
  logic [2:0]            r_arsize;
  logic                  r_rready;
  logic                  r_awvalid;
  logic [ADDR_W-1:0]     r_awaddr;
  logic [7:0]            r_awlen;
  logic [2:0]            r_awsize;
  logic                  r_wvalid;
  logic [AXI_DW-1:0]     r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_wlast;
  logic                  r_bready;

  logic [ADDR_W-1:0]     w_req_addr;
  logic [7:0]            w_req_len;
  logic [2:0]            w_req_size;
  logic [AXI_DW-1:0]     w_gen_data;
  logic [STRB_W-1:0]     w_gen_strb;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_w_final;
  logic                  w_aw_seen;
  logic                  w_w_seen;
  logic                  w_b_hs;
  logic                  w_unused;

  axi_wstrb_gen #(
    .DW(AXI_DW)
  ) u_wstrb_gen (
    .i_cachable (i_uni_cachable),
    .i_offset   (i_uni_addr[OFF_W-1:0]),
    .i_size     (i_uni_size),
    .i_data     (i_uni_wdata[AXI_DW-1:0]),
    .o_data     (w_gen_data),
    .o_strb     (w_gen_strb)
  );

  // Shape the address phase from the incoming request: line-aligned burst or raw single beat
  always_comb begin
    if (i_uni_cachable) begin
      w_req_addr = {i_uni_addr[ADDR_W-1:LINE_OFF], {LINE_OFF{1'b0}}};
      w_req_len  = AXI_LEN_LINE;
      w_req_size = AXI_SIZE_8B;
    end else begin
      w_req_addr = i_uni_addr;
      w_req_len  = AXI_LEN_SINGLE;
      w_req_size = {1'b0, i_uni_size};
    end
  end

  assign w_ar_hs   = r_arvalid & i_axi_arready;
  assign w_r_hs    = r_rready & i_axi_rvalid;
  assign w_aw_hs   = r_awvalid & i_axi_awready;
  assign w_w_hs    = r_wvalid & i_axi_wready;
  assign w_w_final = w_w_hs & r_wlast;
  assign w_aw_seen = r_aw_done | w_aw_hs;
  assign w_w_seen  = r_w_done | w_w_final;
  assign w_b_hs    = r_bready & i_axi_bvalid;
  // Responses carry no error path in this bridge
  assign w_unused  = ^{i_axi_rresp, i_axi_bresp};

  // Request sequencer with all AXI and uni outputs registered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cach      <= 1'b0;
      r_wdata_hi  <= '0;
      r_rbeat     <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_uni_ready <= 1'b0;
      r_rdata     <= '0;
      r_arvalid   <= 1'b0;
      r_araddr    <= '0;
      r_arlen     <= 8'd0;
      r_arsize    <= 3'd0;
      r_rready    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_awaddr    <= '0;
      r_awlen     <= 8'd0;
      r_awsize    <= 3'd0;
      r_wvalid    <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_wlast     <= 1'b0;
      r_bready    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_uni_valid) begin
            r_cach     <= i_uni_cachable;
            r_wdata_hi <= i_uni_wdata[2*AXI_DW-1:AXI_DW];
            r_rbeat    <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            if (i_uni_reqtyp == REQ_WRITE) begin
              r_state   <= ST_WADDR;
              r_awvalid <= 1'b1;
              r_awaddr  <= w_req_addr;
              r_awlen   <= w_req_len;
              r_awsize  <= w_req_size;
              r_wvalid  <= 1'b1;
              r_wdata   <= w_gen_data;
              r_wstrb   <= w_gen_strb;
              r_wlast   <= ~i_uni_cachable;
            end else begin
              r_state   <= ST_RADDR;
              r_arvalid <= 1'b1;
              r_araddr  <= w_req_addr;
              r_arlen   <= w_req_len;
              r_arsize  <= w_req_size;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RADDR: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RDATA;
          end else begin
            r_state <= ST_RADDR;
          end
        end
        ST_RDATA: begin
          if (w_r_hs) begin
            r_rbeat <= ~r_rbeat;
            if (!r_cach) begin
              r_rdata <= {{AXI_DW{1'b0}}, i_axi_rdata};
            end else if (r_rbeat) begin
              r_rdata[2*AXI_DW-1:AXI_DW] <= i_axi_rdata;
            end else begin
              r_rdata[AXI_DW-1:0] <= i_axi_rdata;
            end
            if (i_axi_rlast) begin
              r_rready    <= 1'b0;
              r_uni_ready <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_RDATA;
            end
          end else begin
            r_state <= ST_RDATA;
          end
        end
        ST_WADDR: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
          end
          // First line beat accepted: present the upper half as the last beat
          if (w_w_final) begin
            r_wvalid <= 1'b0;
            r_wlast  <= 1'b0;
            r_wstrb  <= '0;
          end else if (w_w_hs) begin
            r_wdata <= r_wdata_hi;
            r_wlast <= 1'b1;
          end
          r_aw_done <= w_aw_seen;
          r_w_done  <= w_w_seen;
          if (w_aw_seen && w_w_seen) begin
            r_bready <= 1'b1;
            r_state  <= ST_WRESP;
          end else begin
            r_state <= ST_WADDR;
          end
        end
        ST_WRESP: begin
          if (w_b_hs) begin
            r_bready    <= 1'b0;
            r_uni_ready <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_state <= ST_WRESP;
          end
        end
        ST_DONE: begin
          r_uni_ready <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_uni_ready <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_uni_ready   = r_uni_ready;
  assign o_uni_rdata   = r_rdata;
  assign o_axi_arvalid = r_arvalid;
  assign o_axi_arid    = '0;
  assign o_axi_araddr  = r_araddr;
  assign o_axi_arlen   = r_arlen;
  assign o_axi_arsize  = r_arsize;
  assign o_axi_arburst = AXI_BURST_INCR;
  assign o_axi_rready  = r_rready;
  assign o_axi_awvalid = r_awvalid;
  assign o_axi_awid    = '0;
  assign o_axi_awaddr  = r_awaddr;
  assign o_axi_awlen   = r_awlen;
  assign o_axi_awsize  = r_awsize;
  assign o_axi_awburst = AXI_BURST_INCR;
  assign o_axi_wvalid  = r_wvalid;
  assign o_axi_wdata   = r_wdata;
  assign o_axi_wstrb   = r_wstrb;
  assign o_axi_wlast   = r_wlast;
  assign o_axi_bready  = r_bready;

endmodule

// File: tb/tb_uni_axi_bridge.sv
// Directed bench for uni_axi_bridge: the initial block plays both uni master and AXI
// slave; expected read lines and write beats are queued at issue time and popped on output.
module tb_uni_axi_bridge;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  s;
    logic        l;
  } wbeat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         uni_valid, uni_reqtyp, uni_cachable;
  logic [31:0]  uni_addr;
  logic [127:0] uni_wdata;
  logic [1:0]   uni_size;
  logic         uni_ready;
  logic [127:0] uni_rdata;
  logic         arvalid, arready, rvalid, rlast, rready;
  logic [3:0]   arid, awid;
  logic [31:0]  araddr, awaddr;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst, rresp, bresp;
  logic [63:0]  rdata, wdata;
  logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [7:0]   wstrb;

  logic [127:0] sb_rdata[$];
  wbeat_t       sb_wbeat[$];
  logic [127:0] last_rdata;
  int           n_assert = 0;
  int           n_fail = 0;
  int           lat;
  int           nbeats;

  always #5 clk = ~clk;

  uni_axi_bridge #(.ADDR_W(32), .AXI_DW(64)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_uni_valid(uni_valid), .i_uni_reqtyp(uni_reqtyp), .i_uni_addr(uni_addr),
    .i_uni_wdata(uni_wdata), .i_uni_size(uni_size), .i_uni_cachable(uni_cachable),
    .o_uni_ready(uni_ready), .o_uni_rdata(uni_rdata),
    .o_axi_arvalid(arvalid), .o_axi_arid(arid), .o_axi_araddr(araddr), .o_axi_arlen(arlen),
    .o_axi_arsize(arsize), .o_axi_arburst(arburst), .i_axi_arready(arready),
    .i_axi_rvalid(rvalid), .i_axi_rdata(rdata), .i_axi_rresp(rresp), .i_axi_rlast(rlast),
    .o_axi_rready(rready),
    .o_axi_awvalid(awvalid), .o_axi_awid(awid), .o_axi_awaddr(awaddr), .o_axi_awlen(awlen),
    .o_axi_awsize(awsize), .o_axi_awburst(awburst), .i_axi_awready(awready),
    .o_axi_wvalid(wvalid), .o_axi_wdata(wdata), .o_axi_wstrb(wstrb), .o_axi_wlast(wlast),
    .i_axi_wready(wready),
    .i_axi_bvalid(bvalid), .i_axi_bresp(bresp), .o_axi_bready(bready)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [127:0] d,
                       input logic [1:0] sz, input logic c);
    uni_valid = 1'b1; uni_reqtyp = wr; uni_addr = a; uni_wdata = d;
    uni_size = sz; uni_cachable = c;
    @(negedge clk);
    uni_valid = 1'b0;
  endtask

  // Compare the beat currently presented on W against the next queued expectation
  task automatic w_beat(input string tag);
    wbeat_t e;
    e = '0;
    if (sb_wbeat.size() > 0) e = sb_wbeat.pop_front();
    chk({tag, " wvalid"}, wvalid, 1'b1);
    chk({tag, " wdata"}, wdata, e.d);
    chk({tag, " wstrb"}, wstrb, e.s);
    chk({tag, " wlast"}, wlast, e.l);
  endtask

  // Wait (bounded) for the completion pulse, check the line and the one-cycle pulse width
  task automatic finish_req(input string tag);
    logic [127:0] e;
    int k;
    k = 0;
    e = '0;
    while (!uni_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (sb_rdata.size() > 0) e = sb_rdata.pop_front();
    chk({tag, " uni_ready"}, uni_ready, 1'b1);
    chk({tag, " uni_rdata"}, uni_rdata, e);
    last_rdata = e;
    @(negedge clk);
    chk({tag, " ready pulse width"}, uni_ready, 1'b0);
    chk({tag, " rdata held"}, uni_rdata, e);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    uni_valid = 1'b0; uni_reqtyp = 1'b0; uni_addr = '0; uni_wdata = '0;
    uni_size = 2'd0; uni_cachable = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'd0; rlast = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'd0;
    last_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst uni_ready", uni_ready, 1'b0);
    chk("rst uni_rdata", uni_rdata, 128'd0);
    chk("rst arvalid", arvalid, 1'b0);
    chk("rst awvalid", awvalid, 1'b0);
    chk("rst wvalid", wvalid, 1'b0);
    chk("rst wstrb", wstrb, 8'h00);
    chk("rst wlast", wlast, 1'b0);
    chk("rst rready", rready, 1'b0);
    chk("rst bready", bready, 1'b0);
    chk("rst arburst", arburst, 2'b01);
    chk("rst awburst", awburst, 2'b01);
    rst_n = 1'b1;
    @(negedge clk);

    // Cached line read with AR stalled; a uni request during the stall must be ignored
    sb_rdata.push_back({64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    issue(1'b0, 32'h8000_0018, 128'd0, 2'd0, 1'b1);
    chk("t1 arvalid", arvalid, 1'b1);
    chk("t1 araddr", araddr, 32'h8000_0010);
    chk("t1 arlen", arlen, 8'd1);
    chk("t1 arsize", arsize, 3'd3);
    chk("t1 arid", arid, 4'd0);
    uni_valid = 1'b1; uni_reqtyp = 1'b1;
    @(negedge clk);
    uni_valid = 1'b0;
    chk("t1 arvalid held", arvalid, 1'b1);
    chk("t1 araddr held", araddr, 32'h8000_0010);
    chk("t1 busy ignores uni", awvalid, 1'b0);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("t1 arvalid drop", arvalid, 1'b0);
    chk("t1 rready", rready, 1'b1);
    rvalid = 1'b1; rdata = 64'h1111_1111_1111_1111; rlast = 1'b0;
    @(negedge clk);
    rdata = 64'h2222_2222_2222_2222; rlast = 1'b1;
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    chk("t1 ready after rlast", uni_ready, 1'b1);
    finish_req("t1");

    // Uncached 8 B read with zero-wait AXI: latency counted from the acceptance cycle
    arready = 1'b1; rvalid = 1'b1; rlast = 1'b1; rdata = 64'hCAFE_F00D_1234_5678;
    sb_rdata.push_back({64'd0, 64'hCAFE_F00D_1234_5678});
    uni_valid = 1'b1; uni_reqtyp = 1'b0; uni_addr = 32'h5000_0008;
    uni_size = 2'd3; uni_cachable = 1'b0;
    lat = 1;
    @(negedge clk);
    uni_valid = 1'b0;
    lat++;
    while (!uni_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("t2 latency", lat, 4);
    chk("t2 araddr", araddr, 32'h5000_0008);
    chk("t2 arlen", arlen, 8'd0);
    chk("t2 arsize", arsize, 3'd3);
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    finish_req("t2");

    // Uncached 4 B write at byte offset 4; bresp error must not matter
    sb_wbeat.push_back({64'hDEAD_BEEF_0000_0000, 8'hF0, 1'b1});
    sb_rdata.push_back(last_rdata);
    issue(1'b1, 32'h1000_0004, 128'h0000_0000_DEAD_BEEF, 2'd2, 1'b0);
    chk("t3 awvalid", awvalid, 1'b1);
    chk("t3 awaddr", awaddr, 32'h1000_0004);
    chk("t3 awlen", awlen, 8'd0);
    chk("t3 awsize", awsize, 3'd2);
    chk("t3 awid", awid, 4'd0);
    chk("t3 bready early", bready, 1'b0);
    awready = 1'b1; wready = 1'b1;
    w_beat("t3");
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    chk("t3 awvalid drop", awvalid, 1'b0);
    chk("t3 wvalid drop", wvalid, 1'b0);
    chk("t3 bready", bready, 1'b1);
    bvalid = 1'b1; bresp = 2'b10;
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'd0;
    finish_req("t3");

    // Cached write: W accepted at once, AW stalled five cycles
    sb_wbeat.push_back({64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b0});
    sb_wbeat.push_back({64'hBBBB_BBBB_BBBB_BBBB, 8'hFF, 1'b1});
    sb_rdata.push_back(last_rdata);
    issue(1'b1, 32'h2000_0008, {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 2'd0, 1'b1);
    chk("t4 awaddr", awaddr, 32'h2000_0000);
    chk("t4 awlen", awlen, 8'd1);
    chk("t4 awsize", awsize, 3'd3);
    wready = 1'b1;
    nbeats = 0;
    for (int c = 0; c < 5; c++) begin
      if (wvalid) begin
        w_beat("t4");
        nbeats++;
      end
      chk("t4 bready during stall", bready, 1'b0);
      chk("t4 awvalid during stall", awvalid, 1'b1);
      @(negedge clk);
    end
    chk("t4 beat count", nbeats, 2);
    wready = 1'b0; awready = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    chk("t4 bready", bready, 1'b1);
    chk("t4 awvalid drop", awvalid, 1'b0);
    chk("t4 wvalid drop", wvalid, 1'b0);
    bvalid = 1'b1;
    @(negedge clk);
    bvalid = 1'b0;
    finish_req("t4");

    // Cached read with rvalid toggling 1,0,1: the gap carries junk data and a stray rlast
    sb_rdata.push_back({64'h4444_0000_4444_0001, 64'h3333_0000_3333_0001});
    issue(1'b0, 32'h3000_002C, 128'd0, 2'd1, 1'b1);
    chk("t5 araddr", araddr, 32'h3000_0020);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    rvalid = 1'b1; rdata = 64'h3333_0000_3333_0001; rlast = 1'b0;
    @(negedge clk);
    rvalid = 1'b0; rdata = 64'hBAD0_BAD0_BAD0_BAD0; rlast = 1'b1;
    @(negedge clk);
    chk("t5 no early ready", uni_ready, 1'b0);
    rvalid = 1'b1; rdata = 64'h4444_0000_4444_0001; rlast = 1'b1;
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    chk("t5 ready after rlast", uni_ready, 1'b1);
    finish_req("t5");

    // Reset in the middle of a line read, then a fresh uncached 1 B read
    issue(1'b0, 32'h4000_0000, 128'd0, 2'd0, 1'b1);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("t6 rready before reset", rready, 1'b1);
    rvalid = 1'b1; rdata = 64'h5555_5555_5555_5555; rlast = 1'b0;
    @(negedge clk);
    rvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6 arvalid in reset", arvalid, 1'b0);
    chk("t6 rready in reset", rready, 1'b0);
    chk("t6 awvalid in reset", awvalid, 1'b0);
    chk("t6 wvalid in reset", wvalid, 1'b0);
    chk("t6 bready in reset", bready, 1'b0);
    chk("t6 uni_rdata in reset", uni_rdata, 128'd0);
    sb_rdata.delete();
    last_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sb_rdata.push_back({64'd0, 64'h0000_0000_0000_00A5});
    issue(1'b0, 32'h1000_0003, 128'd0, 2'd0, 1'b0);
    chk("t6 arsize", arsize, 3'd0);
    chk("t6 araddr", araddr, 32'h1000_0003);
    chk("t6 arlen", arlen, 8'd0);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; rdata = 64'h0000_0000_0000_00A5;
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    finish_req("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
